control_sequencer: RTL and testbench
====================================

// Module: control_sequencer
// PURPOSE
//  Hardwired Moore control unit for the datapath; replaces hand-driven control waveforms. Fetches via T0-T2,
//  decodes ir[31:27], then steps T3-T7 execute sequences for the full instruction set.
//  Each T-state lasts STEP_CYCLES clocks, set by parameter. Adds halt, conditional branch and single-step.
// PARAMETERS
//  STEP_CYCLES  2   clocks per T-state (>=1)
//  IR_W         32  instruction width; opcode = ir[IR_W-1 -: 5]
// PORTS
//  clk                      in   1   clock; all state updates on posedge
//  clr                      in   1   synchronous active-high reset
//  ir                       in   32  instruction register contents (stable from end of T2)
//  con_out                  in   1   branch condition flag from datapath CON FF
//  pc_out,zlo_out,zhi_out,hi_out,lo_out,mdr_out,inport_out,c_sign_extended_out,ba_out,r_out,gra,grb,grc,read
//                           out  1 each  drive-class signals
//  pc_enable,pc_increment,mar_enable,mdr_enable,ir_enable,y_enable,z_enable,hi_enable,lo_enable,r_in,
//  con_enable,ram_write,inport_enable,outport_enable   out  1 each  latch-class signals
//  alu_op                   out  5   ALU operation (opcode encoding; OP_ADD when address/branch add)
//  run                      out  1   high unless HALTED/RESET
//  illegal_op               out  1   one-clock pulse at end of T2 on undefined opcode
// BEHAVIOUR
//  - clr=1: state RESET, step counter 0, every output 0 (alu_op=0, run=0) at next edge; wins over all else,
//    incl. mid-instruction (e.g. clr during ld T6 -> read=0, mdr_enable=0 next cycle). First edge with clr=0 -> T0.
//  - Outputs decoded from registered state+step counter only (glitch-free). Drive-class high for all
//    STEP_CYCLES of a step; latch-class high ONLY in last cycle of the step (one load per step).
//  - Step counter 0..STEP_CYCLES-1, wraps to 0 on state advance.
//  - Fetch: T0 pc_out,mar_enable,pc_increment,z_enable | T1 zlo_out,pc_enable,read,mdr_enable | T2 mdr_out,ir_enable.
//  - Execute (T3.. in order; last listed step returns to T0):
//    ldi/addi/andi/ori: grb,ba_out(ldi)|r_out(else),y_enable ; c_sign_extended_out,z_enable,alu_op ; zlo_out,gra,r_in
//    ld : grb,ba_out,y_enable ; c_sign_extended_out,z_enable,OP_ADD ; zlo_out,mar_enable ; read,mdr_enable ; mdr_out,gra,r_in
//    st : as ld T3-T5 ; gra,r_out,mdr_enable (read=0) ; ram_write
//    R-type ALU: grb,r_out,y_enable ; grc,r_out,z_enable,alu_op ; zlo_out,gra,r_in
//    mul/div: gra,r_out,y_enable ; grb,r_out,z_enable,alu_op ; zlo_out,lo_enable ; zhi_out,hi_enable
//    br : gra,r_out,con_enable ; pc_out,y_enable ; c_sign_extended_out,z_enable,OP_ADD ;
//         zlo_out + pc_enable only if con_out=1 sampled in that step's last cycle
//    in: inport_out,gra,r_in | out: gra,r_out,outport_enable | mfhi: hi_out,gra,r_in | mflo: lo_out,gra,r_in
//    nop / undefined: T2 -> T0 directly (undefined also pulses illegal_op)
//    halt: T2 -> HALTED; all outputs 0, run=0; exits only via clr
//  - Instruction latency = (3 + execute steps) * STEP_CYCLES clocks; ldi @ STEP_CYCLES=2 -> 12 clocks.
// CONFIGURATION
//  SEQ_SINGLE_STEP_EN defined: extra input `step` (1 bit); after each instruction (and after reset) sequencer
//   waits in state WAIT, outputs 0, run=1, until step=1 sampled; then T0 next edge. step held high = free run.
//   Not defined: port absent, no WAIT state; last step -> T0 directly.
// STRUCTURE
//  Package cpu_ctrl_pkg: opcode localparams (OP_LD 5'h00, OP_LDI 01, OP_ST 02, OP_ADD 03, OP_SUB 04, OP_AND 05,
//   OP_OR 06, OP_SHR 07, OP_SHL 08, OP_ROR 09, OP_ROL 0A, OP_NEG 0B, OP_NOT 0C, OP_ADDI 0D, OP_ANDI 0E,
//   OP_ORI 0F, OP_MUL 10, OP_DIV 11, OP_BR 12, OP_IN 16, OP_OUT 17, OP_MFHI 18, OP_MFLO 19, OP_NOP 1A, OP_HALT 1B),
//   state encoding enum, control-word bit indices.
//  One sub-module: seq_step_timer (step counter, emits step_last); FSM + output decode in top.
// TESTING
//  1 clr 1 cycle, ir=0x0900_0005 (ldi r2,5), STEP_CYCLES=2 -> T0 pc_out/mar_enable/pc_increment; each latch
//    signal high exactly 1 clk; T5 zlo_out,gra,r_in; back at T0 on clock 13.
//  2 ir=0x1A20_0000 (add r4,r4,r0) -> T4 alu_op=5'h03, grc+r_out 2 clks, z_enable 1 clk; done in 6 steps.
//  3 br with con_out=0 then 1 -> pc_enable absent at T6 for 0, single 1-clk pulse for 1.
//  4 ir=0xD800_0000 (halt) -> HALTED after T2, run=0, outputs 0 for 50 clks; clr -> T0 restarts.
//  5 clr asserted mid-ld at T6 step 0 -> next edge all outputs 0, run=0; release -> T0 fetch.
//  6 STEP_CYCLES=1 and SEQ_SINGLE_STEP_EN: no activity until step pulse; one pulse = one instruction; opcode 1F -> illegal_op pulse.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the control sequencer: opcodes, FSM state encoding,
// control-word bit positions and small opcode-classification helpers.
package cpu_ctrl_pkg;

    localparam logic [4:0] OP_LD   = 5'h00;
    localparam logic [4:0] OP_LDI  = 5'h01;
    localparam logic [4:0] OP_ST   = 5'h02;
    localparam logic [4:0] OP_ADD  = 5'h03;
    localparam logic [4:0] OP_SUB  = 5'h04;
    localparam logic [4:0] OP_AND  = 5'h05;
    localparam logic [4:0] OP_OR   = 5'h06;
    localparam logic [4:0] OP_SHR  = 5'h07;
    localparam logic [4:0] OP_SHL  = 5'h08;
    localparam logic [4:0] OP_ROR  = 5'h09;
    localparam logic [4:0] OP_ROL  = 5'h0A;
    localparam logic [4:0] OP_NEG  = 5'h0B;
    localparam logic [4:0] OP_NOT  = 5'h0C;
    localparam logic [4:0] OP_ADDI = 5'h0D;
    localparam logic [4:0] OP_ANDI = 5'h0E;
    localparam logic [4:0] OP_ORI  = 5'h0F;
    localparam logic [4:0] OP_MUL  = 5'h10;
    localparam logic [4:0] OP_DIV  = 5'h11;
    localparam logic [4:0] OP_BR   = 5'h12;
    localparam logic [4:0] OP_IN   = 5'h16;
    localparam logic [4:0] OP_OUT  = 5'h17;
    localparam logic [4:0] OP_MFHI = 5'h18;
    localparam logic [4:0] OP_MFLO = 5'h19;
    localparam logic [4:0] OP_NOP  = 5'h1A;
    localparam logic [4:0] OP_HALT = 5'h1B;

    typedef enum logic [3:0] {
        ST_RESET  = 4'd0,
        ST_T0     = 4'd1,
        ST_T1     = 4'd2,
        ST_T2     = 4'd3,
        ST_T3     = 4'd4,
        ST_T4     = 4'd5,
        ST_T5     = 4'd6,
        ST_T6     = 4'd7,
        ST_T7     = 4'd8,
        ST_HALTED = 4'd9,
        ST_WAIT   = 4'd10
    } seq_state_e;

    // Drive-class bits occupy 0..13, latch-class bits 14..27.
    localparam int CW_PC_OUT      = 0;
    localparam int CW_ZLO_OUT     = 1;
    localparam int CW_ZHI_OUT     = 2;
    localparam int CW_HI_OUT      = 3;
    localparam int CW_LO_OUT      = 4;
    localparam int CW_MDR_OUT     = 5;
    localparam int CW_INPORT_OUT  = 6;
    localparam int CW_CSE_OUT     = 7;
    localparam int CW_BA_OUT      = 8;
    localparam int CW_R_OUT       = 9;
    localparam int CW_GRA         = 10;
    localparam int CW_GRB         = 11;
    localparam int CW_GRC         = 12;
    localparam int CW_READ        = 13;
    localparam int CW_PC_EN       = 14;
    localparam int CW_PC_INC      = 15;
    localparam int CW_MAR_EN      = 16;
    localparam int CW_MDR_EN      = 17;
    localparam int CW_IR_EN       = 18;
    localparam int CW_Y_EN        = 19;
    localparam int CW_Z_EN        = 20;
    localparam int CW_HI_EN       = 21;
    localparam int CW_LO_EN       = 22;
    localparam int CW_R_IN        = 23;
    localparam int CW_CON_EN      = 24;
    localparam int CW_RAM_WR      = 25;
    localparam int CW_INPORT_EN   = 26;
    localparam int CW_OUTPORT_EN  = 27;
    localparam int CW_W           = 28;

    localparam logic [CW_W-1:0] CW_LATCH_MASK = 28'hFFF_C000;

    // Number of T3+ steps; zero means the instruction finishes at T2.
    function automatic logic [2:0] exec_steps(input logic [4:0] op);
        logic [2:0] n;
        n = 3'd0;
        case (op)
            OP_LD, OP_ST:                                   n = 3'd5;
            OP_LDI, OP_ADDI, OP_ANDI, OP_ORI:               n = 3'd3;
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_NEG, OP_NOT:                 n = 3'd3;
            OP_MUL, OP_DIV, OP_BR:                          n = 3'd4;
            OP_IN, OP_OUT, OP_MFHI, OP_MFLO:                n = 3'd1;
            default:                                        n = 3'd0;
        endcase
        return n;
    endfunction

    function automatic logic op_defined(input logic [4:0] op);
        return (exec_steps(op) != 3'd0) || (op == OP_NOP) || (op == OP_HALT);
    endfunction

    // Immediate forms reuse the ALU code of their register-register twin.
    function automatic logic [4:0] imm_alu_op(input logic [4:0] op);
        logic [4:0] a;
        case (op)
            OP_ANDI: a = OP_AND;
            OP_ORI:  a = OP_OR;
            default: a = OP_ADD;
        endcase
        return a;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Per-T-state cycle counter; step_last marks the final clock of the current step.
module seq_step_timer #(
    parameter int STEP_CYCLES = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic step_last
);
    localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign step_last = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!en || step_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: T0-T2 fetch, opcode decode, T3-T7 execute.
// Optional single-step mode (WAIT state plus `step` input) via SEQ_SINGLE_STEP_EN.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int STEP_CYCLES = 2,
    parameter int IR_W        = 32
) (
    input  logic            clk,
    input  logic            clr,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [IR_W-1:0] ir,
    input  logic            con_out,
    output logic            pc_out,
    output logic            zlo_out,
    output logic            zhi_out,
    output logic            hi_out,
    output logic            lo_out,
    output logic            mdr_out,
    output logic            inport_out,
    output logic            c_sign_extended_out,
    output logic            ba_out,
    output logic            r_out,
    output logic            gra,
    output logic            grb,
    output logic            grc,
    output logic            read,
    output logic            pc_enable,
    output logic            pc_increment,
    output logic            mar_enable,
    output logic            mdr_enable,
    output logic            ir_enable,
    output logic            y_enable,
    output logic            z_enable,
    output logic            hi_enable,
    output logic            lo_enable,
    output logic            r_in,
    output logic            con_enable,
    output logic            ram_write,
    output logic            inport_enable,
    output logic            outport_enable,
    output logic [4:0]      alu_op,
    output logic            run,
    output logic            illegal_op,
    output logic [3:0]      dbg_state
);
`ifdef SEQ_SINGLE_STEP_EN
    localparam seq_state_e DONE_STATE = ST_WAIT;
`else
    localparam seq_state_e DONE_STATE = ST_T0;
`endif

    seq_state_e       state_q, state_d, last_exec;
    logic [4:0]       op_q, op_d;
    logic [4:0]       ir_op;
    logic             step_last;
    logic             in_tstate;
    logic [CW_W-1:0]  cw, cw_out;
    logic             unused_ir;

    assign ir_op     = ir[IR_W-1 -: 5];
    assign unused_ir = ^ir[IR_W-6:0];
    assign in_tstate = (state_q >= ST_T0) && (state_q <= ST_T7);
    assign last_exec = seq_state_e'(4'(ST_T2) + {1'b0, exec_steps(op_q)});
    assign dbg_state = state_q;

    seq_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .en        (in_tstate),
        .step_last (step_last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_RESET;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        case (state_q)
            ST_RESET: state_d = DONE_STATE;
            ST_T0, ST_T1: begin
                if (step_last) state_d = seq_state_e'(4'(state_q) + 4'd1);
            end
            ST_T2: begin
                if (step_last) begin
                    op_d = ir_op;
                    if (ir_op == OP_HALT)               state_d = ST_HALTED;
                    else if (exec_steps(ir_op) == 3'd0) state_d = DONE_STATE;
                    else                                state_d = ST_T3;
                end
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                if (step_last) begin
                    state_d = (state_q == last_exec) ? DONE_STATE
                                                     : seq_state_e'(4'(state_q) + 4'd1);
                end
            end
            ST_HALTED: state_d = ST_HALTED;
`ifdef SEQ_SINGLE_STEP_EN
            ST_WAIT: if (step) state_d = ST_T0;
`endif
            default: state_d = ST_RESET;
        endcase
    end

    // Control word per step; latch-class bits are gated to the step's last clock below.
    always_comb begin
        cw     = '0;
        alu_op = '0;
        case (state_q)
            ST_T0: begin
                cw[CW_PC_OUT] = 1'b1; cw[CW_MAR_EN] = 1'b1;
                cw[CW_PC_INC] = 1'b1; cw[CW_Z_EN]   = 1'b1;
            end
            ST_T1: begin
                cw[CW_ZLO_OUT] = 1'b1; cw[CW_PC_EN]  = 1'b1;
                cw[CW_READ]    = 1'b1; cw[CW_MDR_EN] = 1'b1;
            end
            ST_T2: begin
                cw[CW_MDR_OUT] = 1'b1; cw[CW_IR_EN] = 1'b1;
            end
            ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                case (op_q)
                    OP_LDI, OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state_q)
                            ST_T3: begin
                                cw[CW_GRB] = 1'b1; cw[CW_Y_EN] = 1'b1;
                                if (op_q == OP_LDI) cw[CW_BA_OUT] = 1'b1;
                                else                cw[CW_R_OUT]  = 1'b1;
                            end
                            ST_T4: begin
                                cw[CW_CSE_OUT] = 1'b1; cw[CW_Z_EN] = 1'b1;
                                alu_op = imm_alu_op(op_q);
                            end
                            ST_T5: begin
                                cw[CW_ZLO_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_ST: begin
                        case (state_q)
                            ST_T3: begin
                                cw[CW_GRB] = 1'b1; cw[CW_BA_OUT] = 1'b1; cw[CW_Y_EN] = 1'b1;
                            end
                            ST_T4: begin
                                cw[CW_CSE_OUT] = 1'b1; cw[CW_Z_EN] = 1'b1; alu_op = OP_ADD;
                            end
                            ST_T5: begin
                                cw[CW_ZLO_OUT] = 1'b1; cw[CW_MAR_EN] = 1'b1;
                            end
                            ST_T6: begin
                                cw[CW_MDR_EN] = 1'b1;
                                if (op_q == OP_LD) begin
                                    cw[CW_READ] = 1'b1;
                                end else begin
                                    cw[CW_GRA] = 1'b1; cw[CW_R_OUT] = 1'b1;
                                end
                            end
                            ST_T7: begin
                                if (op_q == OP_LD) begin
                                    cw[CW_MDR_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                                end else begin
                                    cw[CW_RAM_WR] = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
                    OP_ROR, OP_ROL, OP_NEG, OP_NOT: begin
                        case (state_q)
                            ST_T3: begin
                                cw[CW_GRB] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_Y_EN] = 1'b1;
                            end
                            ST_T4: begin
                                cw[CW_GRC] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_Z_EN] = 1'b1;
                                alu_op = op_q;
                            end
                            ST_T5: begin
                                cw[CW_ZLO_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state_q)
                            ST_T3: begin
                                cw[CW_GRA] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_Y_EN] = 1'b1;
                            end
                            ST_T4: begin
                                cw[CW_GRB] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_Z_EN] = 1'b1;
                                alu_op = op_q;
                            end
                            ST_T5: begin
                                cw[CW_ZLO_OUT] = 1'b1; cw[CW_LO_EN] = 1'b1;
                            end
                            ST_T6: begin
                                cw[CW_ZHI_OUT] = 1'b1; cw[CW_HI_EN] = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state_q)
                            ST_T3: begin
                                cw[CW_GRA] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_CON_EN] = 1'b1;
                            end
                            ST_T4: begin
                                cw[CW_PC_OUT] = 1'b1; cw[CW_Y_EN] = 1'b1;
                            end
                            ST_T5: begin
                                cw[CW_CSE_OUT] = 1'b1; cw[CW_Z_EN] = 1'b1; alu_op = OP_ADD;
                            end
                            ST_T6: begin
                                // Branch taken only when the CON flag is set.
                                cw[CW_ZLO_OUT] = con_out; cw[CW_PC_EN] = con_out;
                            end
                            default: ;
                        endcase
                    end
                    OP_IN: begin
                        cw[CW_INPORT_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_GRA] = 1'b1; cw[CW_R_OUT] = 1'b1; cw[CW_OUTPORT_EN] = 1'b1;
                    end
                    OP_MFHI: begin
                        cw[CW_HI_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                    end
                    OP_MFLO: begin
                        cw[CW_LO_OUT] = 1'b1; cw[CW_GRA] = 1'b1; cw[CW_R_IN] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign cw_out     = step_last ? cw : (cw & ~CW_LATCH_MASK);
    assign run        = (state_q != ST_RESET) && (state_q != ST_HALTED);
    assign illegal_op = (state_q == ST_T2) && step_last && !op_defined(ir_op);

    assign pc_out              = cw_out[CW_PC_OUT];
    assign zlo_out             = cw_out[CW_ZLO_OUT];
    assign zhi_out             = cw_out[CW_ZHI_OUT];
    assign hi_out              = cw_out[CW_HI_OUT];
    assign lo_out              = cw_out[CW_LO_OUT];
    assign mdr_out             = cw_out[CW_MDR_OUT];
    assign inport_out          = cw_out[CW_INPORT_OUT];
    assign c_sign_extended_out = cw_out[CW_CSE_OUT];
    assign ba_out              = cw_out[CW_BA_OUT];
    assign r_out               = cw_out[CW_R_OUT];
    assign gra                 = cw_out[CW_GRA];
    assign grb                 = cw_out[CW_GRB];
    assign grc                 = cw_out[CW_GRC];
    assign read                = cw_out[CW_READ];
    assign pc_enable           = cw_out[CW_PC_EN];
    assign pc_increment        = cw_out[CW_PC_INC];
    assign mar_enable          = cw_out[CW_MAR_EN];
    assign mdr_enable          = cw_out[CW_MDR_EN];
    assign ir_enable           = cw_out[CW_IR_EN];
    assign y_enable            = cw_out[CW_Y_EN];
    assign z_enable            = cw_out[CW_Z_EN];
    assign hi_enable           = cw_out[CW_HI_EN];
    assign lo_enable           = cw_out[CW_LO_EN];
    assign r_in                = cw_out[CW_R_IN];
    assign con_enable          = cw_out[CW_CON_EN];
    assign ram_write           = cw_out[CW_RAM_WR];
    assign inport_enable       = cw_out[CW_INPORT_EN];
    assign outport_enable      = cw_out[CW_OUTPORT_EN];

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected cycle traces built from the
// instruction-level step tables, random back-to-back programs, halt, mid-instruction clr.
`timescale 1ns/1ps
module tb_control_sequencer;
`ifdef SEQ_SINGLE_STEP_EN
  localparam int SC = 1;
  localparam bit SS = 1'b1;
`else
  localparam int SC = 2;
  localparam bit SS = 1'b0;
`endif

  localparam logic [27:0] M_PC_OUT  = 28'd1 << 0;
  localparam logic [27:0] M_ZLO     = 28'd1 << 1;
  localparam logic [27:0] M_ZHI     = 28'd1 << 2;
  localparam logic [27:0] M_HI_OUT  = 28'd1 << 3;
  localparam logic [27:0] M_LO_OUT  = 28'd1 << 4;
  localparam logic [27:0] M_MDR_OUT = 28'd1 << 5;
  localparam logic [27:0] M_IN_OUT  = 28'd1 << 6;
  localparam logic [27:0] M_CSE     = 28'd1 << 7;
  localparam logic [27:0] M_BA_OUT  = 28'd1 << 8;
  localparam logic [27:0] M_R_OUT   = 28'd1 << 9;
  localparam logic [27:0] M_GRA     = 28'd1 << 10;
  localparam logic [27:0] M_GRB     = 28'd1 << 11;
  localparam logic [27:0] M_GRC     = 28'd1 << 12;
  localparam logic [27:0] M_READ    = 28'd1 << 13;
  localparam logic [27:0] M_PC_EN   = 28'd1 << 14;
  localparam logic [27:0] M_PC_INC  = 28'd1 << 15;
  localparam logic [27:0] M_MAR_EN  = 28'd1 << 16;
  localparam logic [27:0] M_MDR_EN  = 28'd1 << 17;
  localparam logic [27:0] M_IR_EN   = 28'd1 << 18;
  localparam logic [27:0] M_Y_EN    = 28'd1 << 19;
  localparam logic [27:0] M_Z_EN    = 28'd1 << 20;
  localparam logic [27:0] M_HI_EN   = 28'd1 << 21;
  localparam logic [27:0] M_LO_EN   = 28'd1 << 22;
  localparam logic [27:0] M_R_IN    = 28'd1 << 23;
  localparam logic [27:0] M_CON_EN  = 28'd1 << 24;
  localparam logic [27:0] M_RAM_WR  = 28'd1 << 25;
  localparam logic [27:0] M_INP_EN  = 28'd1 << 26;
  localparam logic [27:0] M_OUTP_EN = 28'd1 << 27;

  typedef struct packed {
    logic        wait_rec;
    logic        early;
    logic        hold_con;
    logic        cyc0;
    logic        run;
    logic        ill;
    logic [3:0]  stp;
    logic [4:0]  alu;
    logic [27:0] sig;
  } exp_t;

  logic        clk, clr, con_out, step;
  logic [31:0] ir;
  logic pc_out, zlo_out, zhi_out, hi_out, lo_out, mdr_out, inport_out, c_sign_extended_out;
  logic ba_out, r_out, gra, grb, grc, read, pc_enable, pc_increment, mar_enable, mdr_enable;
  logic ir_enable, y_enable, z_enable, hi_enable, lo_enable, r_in, con_enable, ram_write;
  logic inport_enable, outport_enable, run, illegal_op;
  logic [4:0]  alu_op;
  logic [3:0]  dbg_state;
  logic [27:0] obs;

  exp_t       exp_q[$];
  logic [4:0] cur_op;
  int         n_checks, n_fail;

  control_sequencer #(.STEP_CYCLES(SC), .IR_W(32)) dut (
    .clk(clk), .clr(clr),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step),
`endif
    .ir(ir), .con_out(con_out),
    .pc_out(pc_out), .zlo_out(zlo_out), .zhi_out(zhi_out), .hi_out(hi_out), .lo_out(lo_out),
    .mdr_out(mdr_out), .inport_out(inport_out), .c_sign_extended_out(c_sign_extended_out),
    .ba_out(ba_out), .r_out(r_out), .gra(gra), .grb(grb), .grc(grc), .read(read),
    .pc_enable(pc_enable), .pc_increment(pc_increment), .mar_enable(mar_enable),
    .mdr_enable(mdr_enable), .ir_enable(ir_enable), .y_enable(y_enable), .z_enable(z_enable),
    .hi_enable(hi_enable), .lo_enable(lo_enable), .r_in(r_in), .con_enable(con_enable),
    .ram_write(ram_write), .inport_enable(inport_enable), .outport_enable(outport_enable),
    .alu_op(alu_op), .run(run), .illegal_op(illegal_op), .dbg_state(dbg_state)
  );

  assign obs = {outport_enable, inport_enable, ram_write, con_enable, r_in, lo_enable,
                hi_enable, z_enable, y_enable, ir_enable, mdr_enable, mar_enable,
                pc_increment, pc_enable, read, grc, grb, gra, r_out, ba_out,
                c_sign_extended_out, inport_out, mdr_out, lo_out, hi_out, zhi_out,
                zlo_out, pc_out};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit is_defined(input logic [4:0] op);
    return (op <= 5'h12) || (op >= 5'h16 && op <= 5'h1B);
  endfunction

  task automatic push_step(input logic [27:0] drv, input logic [27:0] lat,
                           input logic [4:0] alu, input int stp);
    exp_t r;
    for (int c = 0; c < SC; c++) begin
      r          = '0;
      r.sig      = drv | ((c == SC - 1) ? lat : 28'd0);
      r.alu      = alu;
      r.run      = 1'b1;
      r.ill      = (stp == 2) && (c == SC - 1) && !is_defined(cur_op);
      r.early    = (stp < 2);
      r.hold_con = (stp == 6) && (cur_op == 5'h12);
      r.cyc0     = (c == 0);
      r.stp      = 4'(stp);
      exp_q.push_back(r);
    end
  endtask

  // Reference: the instruction's step list straight from the control tables.
  task automatic build_trace(input logic [4:0] op, input bit con);
    exp_t w;
    logic [4:0] a;
    exp_q.delete();
    cur_op = op;
    if (SS) begin
      w = '0; w.wait_rec = 1'b1; w.early = 1'b1; w.run = 1'b1;
      exp_q.push_back(w);
    end
    push_step(M_PC_OUT, M_MAR_EN | M_PC_INC | M_Z_EN, 5'h00, 0);
    push_step(M_ZLO | M_READ, M_PC_EN | M_MDR_EN, 5'h00, 1);
    push_step(M_MDR_OUT, M_IR_EN, 5'h00, 2);
    if (op == 5'h01 || op == 5'h0D || op == 5'h0E || op == 5'h0F) begin
      a = (op == 5'h0E) ? 5'h05 : (op == 5'h0F) ? 5'h06 : 5'h03;
      push_step(M_GRB | ((op == 5'h01) ? M_BA_OUT : M_R_OUT), M_Y_EN, 5'h00, 3);
      push_step(M_CSE, M_Z_EN, a, 4);
      push_step(M_ZLO | M_GRA, M_R_IN, 5'h00, 5);
    end else if (op == 5'h00 || op == 5'h02) begin
      push_step(M_GRB | M_BA_OUT, M_Y_EN, 5'h00, 3);
      push_step(M_CSE, M_Z_EN, 5'h03, 4);
      push_step(M_ZLO, M_MAR_EN, 5'h00, 5);
      if (op == 5'h00) begin
        push_step(M_READ, M_MDR_EN, 5'h00, 6);
        push_step(M_MDR_OUT | M_GRA, M_R_IN, 5'h00, 7);
      end else begin
        push_step(M_GRA | M_R_OUT, M_MDR_EN, 5'h00, 6);
        push_step(28'd0, M_RAM_WR, 5'h00, 7);
      end
    end else if (op >= 5'h03 && op <= 5'h0C) begin
      push_step(M_GRB | M_R_OUT, M_Y_EN, 5'h00, 3);
      push_step(M_GRC | M_R_OUT, M_Z_EN, op, 4);
      push_step(M_ZLO | M_GRA, M_R_IN, 5'h00, 5);
    end else if (op == 5'h10 || op == 5'h11) begin
      push_step(M_GRA | M_R_OUT, M_Y_EN, 5'h00, 3);
      push_step(M_GRB | M_R_OUT, M_Z_EN, op, 4);
      push_step(M_ZLO, M_LO_EN, 5'h00, 5);
      push_step(M_ZHI, M_HI_EN, 5'h00, 6);
    end else if (op == 5'h12) begin
      push_step(M_GRA | M_R_OUT, M_CON_EN, 5'h00, 3);
      push_step(M_PC_OUT, M_Y_EN, 5'h00, 4);
      push_step(M_CSE, M_Z_EN, 5'h03, 5);
      push_step(con ? M_ZLO : 28'd0, con ? M_PC_EN : 28'd0, 5'h00, 6);
    end else if (op == 5'h16) push_step(M_IN_OUT | M_GRA, M_R_IN, 5'h00, 3);
    else if (op == 5'h17) push_step(M_GRA | M_R_OUT, M_OUTP_EN, 5'h00, 3);
    else if (op == 5'h18) push_step(M_HI_OUT | M_GRA, M_R_IN, 5'h00, 3);
    else if (op == 5'h19) push_step(M_LO_OUT | M_GRA, M_R_IN, 5'h00, 3);
  endtask

  task automatic check_quiet(input string tag, input logic exp_run);
    n_checks++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL %s ctrl: got %h want 0000000", tag, obs);
    end
    n_checks++;
    if (alu_op !== 5'h00) begin
      n_fail++; $display("FAIL %s alu_op: got %h want 00", tag, alu_op);
    end
    n_checks++;
    if (run !== exp_run || illegal_op !== 1'b0) begin
      n_fail++; $display("FAIL %s run/illegal: got %b%b want %b0", tag, run, illegal_op, exp_run);
    end
  endtask

  // driver: plays one instruction, checking every cycle; optional clr at T<abort_stp> cycle 0
  task automatic run_instr(input logic [31:0] irv, input bit con, input int abort_stp, input string tag);
    exp_t r;
    bit   abort;
    build_trace(irv[31:27], con);
    while (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      abort   = !r.wait_rec && r.cyc0 && (int'(r.stp) == abort_stp);
      ir      = r.early ? $urandom : irv;
      con_out = r.hold_con ? con : 1'($urandom_range(0, 1));
      step    = r.wait_rec ? 1'b1 : 1'($urandom_range(0, 1));
      clr     = abort;
      #1;
      n_checks++;
      if (obs !== r.sig) begin
        n_fail++; $display("FAIL %s ctrl T%0d: got %h want %h", tag, r.stp, obs, r.sig);
      end
      n_checks++;
      if (alu_op !== r.alu) begin
        n_fail++; $display("FAIL %s alu_op T%0d: got %h want %h", tag, r.stp, alu_op, r.alu);
      end
      n_checks++;
      if (run !== r.run || illegal_op !== r.ill) begin
        n_fail++;
        $display("FAIL %s run/illegal T%0d: got %b%b want %b%b", tag, r.stp, run, illegal_op, r.run, r.ill);
      end
      @(posedge clk); #1;
      if (abort) begin
        check_quiet({tag, " after clr"}, 1'b0);
        clr = 1'b0;
        @(posedge clk); #1;
        exp_q.delete();
      end
    end
  endtask

  task automatic do_reset(input int cycles);
    clr = 1'b1;
    for (int i = 0; i < cycles; i++) begin
      ir = $urandom; con_out = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check_quiet("reset", 1'b0);
    end
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset(3);
    n_checks++;
    if (pc_out !== !SS || run !== 1'b1) begin
      n_fail++; $display("FAIL reset_exit: got pc_out=%b run=%b want %b 1", pc_out, run, !SS);
    end
  endtask

  task automatic test_ldi();
    run_instr(32'h0900_0005, 1'b0, -1, "ldi");
    n_checks++;
    if (pc_out !== !SS || mar_enable !== (SC == 1 && !SS)) begin
      n_fail++; $display("FAIL ldi_next_fetch: got pc_out=%b mar=%b", pc_out, mar_enable);
    end
  endtask

  task automatic test_add();
    run_instr(32'h1A20_0000, 1'b0, -1, "add");
  endtask

  task automatic test_branch();
    run_instr(32'h9000_0010, 1'b0, -1, "br_nt");
    run_instr(32'h9000_0010, 1'b1, -1, "br_t");
  endtask

  task automatic test_halt();
    run_instr(32'hD800_0000, 1'b0, -1, "halt");
    for (int i = 0; i < 50; i++) begin
      ir = $urandom; con_out = 1'($urandom_range(0, 1)); step = 1'($urandom_range(0, 1));
      #1;
      check_quiet("halted", 1'b0);
      @(posedge clk); #1;
    end
    do_reset(1);
    run_instr(32'h0900_0005, 1'b0, -1, "ldi_after_halt");
  endtask

  task automatic test_clr_mid_ld();
    run_instr(32'h0000_0000 | 32'h0080_0004, 1'b0, 6, "ld_clr");
    run_instr(32'h1100_0000, 1'b0, -1, "st_after_clr");
  endtask

  task automatic test_illegal();
    run_instr(32'hF800_0000, 1'b0, -1, "illegal_1f");
    run_instr(32'h9800_0000, 1'b0, -1, "illegal_13");
    run_instr(32'hD000_0000, 1'b0, -1, "nop");
  endtask

  task automatic test_back_to_back();
    logic [4:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'h1B) op = 5'h1A;
      run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), -1, "random");
    end
  endtask

`ifdef SEQ_SINGLE_STEP_EN
  task automatic test_single_step();
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 5; i++) begin
        ir = $urandom; con_out = 1'($urandom_range(0, 1)); step = 1'b0;
        #1;
        check_quiet("wait_idle", 1'b1);
        @(posedge clk); #1;
      end
      run_instr({5'(k == 2 ? 5'h1F : 5'h16), 27'($urandom)}, 1'b0, -1, "single_step");
    end
  endtask
`endif

  initial begin
    n_checks = 0; n_fail = 0;
    clr = 1'b1; ir = '0; con_out = 1'b0; step = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_ldi();
    test_add();
    test_branch();
    test_illegal();
    test_clr_mid_ld();
    test_halt();
`ifdef SEQ_SINGLE_STEP_EN
    test_single_step();
`endif
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
